// File: rtl/video_timing_pkg.sv
// Shared video timing package: 720p60 defaults, small test raster,
// line/frame total and counter-width helpers, flash FSM states.
package video_timing_pkg;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    localparam int T_H_ACTIVE     = 8;
    localparam int T_H_FP         = 2;
    localparam int T_H_SYNC       = 2;
    localparam int T_H_BP         = 2;
    localparam int T_V_ACTIVE     = 4;
    localparam int T_V_FP         = 1;
    localparam int T_V_SYNC       = 1;
    localparam int T_V_BP         = 1;
    localparam int T_FLASH_FRAMES = 2;
    localparam int T_BOX_W        = 4;
    localparam int T_BOX_H        = 2;

    typedef enum logic {
        DARK = 1'b0,
        LIT  = 1'b1
    } flash_state_t;

    function automatic int line_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    // Counter width for values 0..n-1, never below one bit.
    function automatic int cnt_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster counters with de/hs/vs decode and frame-boundary strobe.
// Ports: I_clk, I_rst_n in; O_hcnt/O_vcnt, O_de, O_hs, O_vs (active-high), O_frame_end out.
module video_timing_core
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter int HW = cnt_width(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW = cnt_width(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    output logic [HW-1:0] O_hcnt,
    output logic [VW-1:0] O_vcnt,
    output logic          O_de,
    output logic          O_hs,
    output logic          O_vs,
    output logic          O_frame_end
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end
        end
    end

    assign O_hcnt      = r_hcnt;
    assign O_vcnt      = r_vcnt;
    assign O_de        = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
    assign O_hs        = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
    // vcnt only moves on the hcnt wrap, so vs changes only at hcnt = 0.
    assign O_vs        = (r_vcnt >= VS_START) && (r_vcnt < VS_END);
    assign O_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/lag_pattern_gen.sv
// Flashing-box lag-test pattern source for hdmi_device, pixel clock domain.
// Ports: I_rgb_clk, I_rst_n, I_enable in; O_rgb_r/g/b, O_rgb_de/hs/vs, O_flash, O_frame_start out.
module lag_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int         H_ACTIVE     = H_ACTIVE_720P,
    parameter int         H_FP         = H_FP_720P,
    parameter int         H_SYNC       = H_SYNC_720P,
    parameter int         H_BP         = H_BP_720P,
    parameter int         V_ACTIVE     = V_ACTIVE_720P,
    parameter int         V_FP         = V_FP_720P,
    parameter int         V_SYNC       = V_SYNC_720P,
    parameter int         V_BP         = V_BP_720P,
    parameter logic       HS_POL       = 1'b1,
    parameter logic       VS_POL       = 1'b1,
    parameter int         FLASH_FRAMES = 30,
    parameter int         BOX_W        = 256,
    parameter int         BOX_H        = 256,
    parameter logic [7:0] BG_LEVEL     = 8'h20
) (
    input  logic       I_rgb_clk,
    input  logic       I_rst_n,
    input  logic       I_enable,
    output logic [7:0] O_rgb_r,
    output logic [7:0] O_rgb_g,
    output logic [7:0] O_rgb_b,
    output logic       O_rgb_de,
    output logic       O_rgb_hs,
    output logic       O_rgb_vs,
    output logic       O_flash,
    output logic       O_frame_start
);

    localparam int HW = cnt_width(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = cnt_width(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int FW = cnt_width(FLASH_FRAMES);

    localparam logic [HW-1:0] X0 = HW'((H_ACTIVE - BOX_W) / 2);
    localparam logic [HW-1:0] X1 = HW'((H_ACTIVE - BOX_W) / 2 + BOX_W);
    localparam logic [VW-1:0] Y0 = VW'((V_ACTIVE - BOX_H) / 2);
    localparam logic [VW-1:0] Y1 = VW'((V_ACTIVE - BOX_H) / 2 + BOX_H);
    localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);

    logic [HW-1:0] w_hcnt;
    logic [VW-1:0] w_vcnt;
    logic          w_de;
    logic          w_hs;
    logic          w_vs;
    logic          w_frame_end;

    video_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .I_clk       (I_rgb_clk),
        .I_rst_n     (I_rst_n),
        .O_hcnt      (w_hcnt),
        .O_vcnt      (w_vcnt),
        .O_de        (w_de),
        .O_hs        (w_hs),
        .O_vs        (w_vs),
        .O_frame_end (w_frame_end)
    );

    flash_state_t  r_state;
    flash_state_t  w_state_nxt;
    logic [FW-1:0] r_frame_cnt;
    logic [FW-1:0] w_frame_cnt_nxt;

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state     <= DARK;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // State and frame count only move at the frame boundary, so no frame is torn.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        if (w_frame_end) begin
            if (!I_enable) begin
                w_state_nxt     = DARK;
                w_frame_cnt_nxt = '0;
            end else if (r_frame_cnt == F_LAST) begin
                w_frame_cnt_nxt = '0;
                w_state_nxt     = (r_state == DARK) ? LIT : DARK;
            end else begin
                w_frame_cnt_nxt = r_frame_cnt + FW'(1);
            end
        end
    end

    logic       w_in_box;
    logic [7:0] w_pix;

    assign w_in_box = (w_hcnt >= X0) && (w_hcnt < X1) &&
                      (w_vcnt >= Y0) && (w_vcnt < Y1);

    always_comb begin
        w_pix = 8'h00;
        if (w_de) begin
            if (w_in_box) begin
                w_pix = (r_state == LIT) ? 8'hFF : 8'h00;
            end else begin
                w_pix = BG_LEVEL;
            end
        end
    end

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_rgb_r       <= 8'h00;
            O_rgb_g       <= 8'h00;
            O_rgb_b       <= 8'h00;
            O_rgb_de      <= 1'b0;
            O_rgb_hs      <= ~HS_POL;
            O_rgb_vs      <= ~VS_POL;
            O_flash       <= 1'b0;
            O_frame_start <= 1'b0;
        end else begin
            O_rgb_r       <= w_pix;
            O_rgb_g       <= w_pix;
            O_rgb_b       <= w_pix;
            O_rgb_de      <= w_de;
            O_rgb_hs      <= w_hs ? HS_POL : ~HS_POL;
            O_rgb_vs      <= w_vs ? VS_POL : ~VS_POL;
            O_flash       <= (r_state == LIT);
            O_frame_start <= (w_hcnt == '0) && (w_vcnt == '0);
        end
    end

endmodule

// File: tb/tb_lag_pattern_gen.sv
// Scoreboard bench for lag_pattern_gen on a 14x7 raster, both sync polarities.
// Expected pixels are queued per frame; a negedge monitor pops and compares.
module tb_lag_pattern_gen;
    import video_timing_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_de, a_hs, a_vs, a_fl, a_fs;
    logic       b_de, b_hs, b_vs, b_fl, b_fs;

    always #5 clk = ~clk;

    lag_pattern_gen #(
        .H_ACTIVE(T_H_ACTIVE), .H_FP(T_H_FP), .H_SYNC(T_H_SYNC), .H_BP(T_H_BP),
        .V_ACTIVE(T_V_ACTIVE), .V_FP(T_V_FP), .V_SYNC(T_V_SYNC), .V_BP(T_V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .FLASH_FRAMES(T_FLASH_FRAMES),
        .BOX_W(T_BOX_W), .BOX_H(T_BOX_H), .BG_LEVEL(8'h20)
    ) dut_a (
        .I_rgb_clk(clk), .I_rst_n(rst_n), .I_enable(en),
        .O_rgb_r(a_r), .O_rgb_g(a_g), .O_rgb_b(a_b),
        .O_rgb_de(a_de), .O_rgb_hs(a_hs), .O_rgb_vs(a_vs),
        .O_flash(a_fl), .O_frame_start(a_fs)
    );

    lag_pattern_gen #(
        .H_ACTIVE(T_H_ACTIVE), .H_FP(T_H_FP), .H_SYNC(T_H_SYNC), .H_BP(T_H_BP),
        .V_ACTIVE(T_V_ACTIVE), .V_FP(T_V_FP), .V_SYNC(T_V_SYNC), .V_BP(T_V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .FLASH_FRAMES(T_FLASH_FRAMES),
        .BOX_W(T_BOX_W), .BOX_H(T_BOX_H), .BG_LEVEL(8'h20)
    ) dut_b (
        .I_rgb_clk(clk), .I_rst_n(rst_n), .I_enable(en),
        .O_rgb_r(b_r), .O_rgb_g(b_g), .O_rgb_b(b_b),
        .O_rgb_de(b_de), .O_rgb_hs(b_hs), .O_rgb_vs(b_vs),
        .O_flash(b_fl), .O_frame_start(b_fs)
    );

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       fl;
        logic [7:0] px;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;

    // Hand-derived frame cadence: FLASH_FRAMES=2, enable dropped in
    // frame 6 (lit) and restored in frame 8.
    bit lit_tab[13] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0};

    // Raster 14x7: de x<8,y<4; hs x=10,11; vs line 5; box x 2..5, y 1..2.
    function automatic exp_t mk(int x, int y, bit lit);
        exp_t e;
        e.de = (x < 8) && (y < 4);
        e.hs = (x == 10) || (x == 11);
        e.vs = (y == 5);
        e.fs = (x == 0) && (y == 0);
        e.fl = lit;
        if (!e.de)
            e.px = 8'h00;
        else if ((y == 1 || y == 2) && (x >= 2 && x <= 5))
            e.px = lit ? 8'hFF : 8'h00;
        else
            e.px = 8'h20;
        return e;
    endfunction

    task automatic push_frame(input bit lit, input int n);
        for (int i = 0; i < n; i++)
            q.push_back(mk(i % 14, i / 14, lit));
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk(nm,
            {1'b0, a_de, a_hs, a_vs, a_fs, a_fl, a_r, a_g, a_b, b_hs, b_vs},
            {1'b0, 5'b00000, 24'h000000, 2'b11});
    endtask

    initial begin : mon
        exp_t e;
        exp_t a;
        bit   ok;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL underflow t=%0t", $time);
                end else begin
                    e = q.pop_front();
                    a.de = a_de;
                    a.hs = a_hs;
                    a.vs = a_vs;
                    a.fs = a_fs;
                    a.fl = a_fl;
                    a.px = a_r;
                    ok = (a === e) && (a_g === e.px) && (a_b === e.px) &&
                         (b_hs === ~e.hs) && (b_vs === ~e.vs) &&
                         (b_de === e.de) && (b_r === e.px) && (b_fl === e.fl);
                    if (!ok) begin
                        bad++;
                        $display("FAIL pix t=%0t got de=%b hs=%b vs=%b fs=%b fl=%b rgb=%h/%h/%h bhs=%b bvs=%b exp de=%b hs=%b vs=%b fs=%b fl=%b rgb=%h bhs=%b bvs=%b",
                                 $time, a_de, a_hs, a_vs, a_fs, a_fl, a_r, a_g, a_b,
                                 b_hs, b_vs, e.de, e.hs, e.vs, e.fs, e.fl, e.px,
                                 ~e.hs, ~e.vs);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset_state");

        for (int f = 0; f < 13; f++)
            push_frame(lit_tab[f], 98);
        push_frame(1'b0, 33);

        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;

        repeat (637) @(posedge clk);
        #1 en = 1'b0;
        repeat (196) @(posedge clk);
        #1 en = 1'b1;
        repeat (474) @(posedge clk);
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        chk("pre_reset_de", {31'd0, a_de}, 32'd1);
        chk("q_empty_1", q.size(), 32'd0);

        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_reset("reset_hold");
        push_frame(1'b0, 98);
        push_frame(1'b0, 98);
        push_frame(1'b1, 98);
        #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (294) @(posedge clk);
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        chk("q_empty_2", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
